// File: rtl/rc5_pkg.sv
// rc5_pkg: shared constants, mode encoding and FSM states for the RC5 job sequencer.
package rc5_pkg;

  localparam int unsigned W        = 64;
  localparam int unsigned B        = 16;
  localparam int unsigned B_LENGTH = $clog2(B);

  // RC5 magic constants for 64-bit words
  localparam logic [63:0] PW = 64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] QW = 64'h9E37_79B9_7F4A_7C15;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadKey,
    StStart,
    StWait,
    StResp
  } state_t;

endpackage

// File: rtl/rc5_job_ctrl_if.sv
// rc5_job_ctrl_if: host-side job request and result handshake of the RC5 job sequencer.
interface rc5_job_ctrl_if #(
  parameter int unsigned W = 64,
  parameter int unsigned B = 16
);

  logic             iJobValid;
  logic             oJobReady;
  logic             iMode;
  logic [8*B-1:0]   iKey;
  logic [W-1:0]     iA;
  logic [W-1:0]     iB;
  logic             oResValid;
  logic             iResReady;
  logic [W-1:0]     oResA;
  logic [W-1:0]     oResB;
  logic             oResErr;

  modport master (
    output iJobValid, iMode, iKey, iA, iB, iResReady,
    input  oJobReady, oResValid, oResA, oResB, oResErr
  );

  modport slave (
    input  iJobValid, iMode, iKey, iA, iB, iResReady,
    output oJobReady, oResValid, oResA, oResB, oResErr
  );

endinterface

// File: rtl/rc5_key_loader.sv
// rc5_key_loader: streams B key bytes into the core key memory, one byte per cycle.
module rc5_key_loader #(
  parameter int unsigned B        = 16,
  parameter int unsigned B_LENGTH = $clog2(B)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*B-1:0]      key,
  output logic [7:0]          keySub,
  output logic [B_LENGTH-1:0] keyAddr,
  output logic                wen,
  output logic                done
);

  logic                activeQ;
  logic [B_LENGTH-1:0] cntQ;

  // Walk the byte counter 0..B-1 once per start request
  always_ff @(posedge clk) begin
    if (rst) begin
      activeQ <= 1'b0;
      cntQ    <= '0;
    end else if (start) begin
      activeQ <= 1'b1;
      cntQ    <= '0;
    end else if (activeQ) begin
      if (cntQ == B_LENGTH'(B - 1)) activeQ <= 1'b0;
      cntQ <= cntQ + 1'b1;
    end
  end

  // Address, data and enable follow the counter while active
  always_comb begin
    wen     = activeQ;
    keyAddr = activeQ ? cntQ : '0;
    keySub  = activeQ ? key[{cntQ, 3'b000} +: 8] : '0;
    done    = activeQ && (cntQ == B_LENGTH'(B - 1));
  end

endmodule

// File: rtl/rc5_job_ctrl.sv
// rc5_job_ctrl: accepts one RC5 job, loads its key, starts the core, waits for done with a
// timeout and returns the result words. Define RC5_KEY_CACHE_EN to skip reloading a key
// identical to the last fully loaded one.
module rc5_job_ctrl #(
  parameter int unsigned W        = 64,
  parameter int unsigned B        = 16,
  parameter int unsigned B_LENGTH = $clog2(B),
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                rst,
  rc5_job_ctrl_if.slave       host,
  output logic [7:0]          oKey_sub_i,
  output logic [B_LENGTH-1:0] oKey_address,
  output logic                oWen,
  output logic                oStartCipher,
  output logic                oStartDecipher,
  output logic [W-1:0]        oCoreA,
  output logic [W-1:0]        oCoreB,
  output logic [W-1:0]        oCoreA_cipher,
  output logic [W-1:0]        oCoreB_cipher,
  input  logic                iDoneCipher,
  input  logic                iDoneDecipher,
  input  logic [W-1:0]        iCoreA_enc,
  input  logic [W-1:0]        iCoreB_enc,
  input  logic [W-1:0]        iCoreA_dec,
  input  logic [W-1:0]        iCoreB_dec
);
  import rc5_pkg::*;

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t         stateQ, stateD;
  logic           modeQ;
  logic [8*B-1:0] keyQ;
  logic [W-1:0]   aQ, bQ;
  logic [TW-1:0]  timerQ;
  logic           prevDoneQ;
  logic [W-1:0]   resAQ, resBQ;
  logic           resErrQ;
  logic           accept, loadStart, loadDone, selDone, doneEvent, timeoutHit, cacheHit, busy;

  assign accept     = (stateQ == StIdle) && host.iJobValid;
  assign selDone    = (modeQ == MODE_DEC) ? iDoneDecipher : iDoneCipher;
  // Only a rising edge counts, so a done level left over from the previous job is ignored
  assign doneEvent  = (stateQ == StWait) && selDone && !prevDoneQ;
  assign timeoutHit = (stateQ == StWait) && !doneEvent && (timerQ == TW'(TIMEOUT - 1));

  rc5_key_loader #(
    .B        (B),
    .B_LENGTH (B_LENGTH)
  ) u_loader (
    .clk     (clk),
    .rst     (rst),
    .start   (loadStart),
    .key     (keyQ),
    .keySub  (oKey_sub_i),
    .keyAddr (oKey_address),
    .wen     (oWen),
    .done    (loadDone)
  );

`ifdef RC5_KEY_CACHE_EN
  logic [8*B-1:0] cacheKeyQ;
  logic           keyValidQ;

  assign cacheHit = keyValidQ && (host.iKey == cacheKeyQ);

  // Remember the last key completely written to the core; a timeout makes it untrusted
  always_ff @(posedge clk) begin
    if (rst) begin
      cacheKeyQ <= '0;
      keyValidQ <= 1'b0;
    end else if ((stateQ == StLoadKey) && loadDone) begin
      cacheKeyQ <= keyQ;
      keyValidQ <= 1'b1;
    end else if (timeoutHit) begin
      keyValidQ <= 1'b0;
    end
  end
`else
  assign cacheHit = 1'b0;
`endif

  // Next-state decode and loader kick-off
  always_comb begin
    stateD    = stateQ;
    loadStart = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (host.iJobValid) begin
          if (cacheHit) begin
            stateD = StStart;
          end else begin
            stateD    = StLoadKey;
            loadStart = 1'b1;
          end
        end
      end
      StLoadKey: if (loadDone) stateD = StStart;
      StStart:   stateD = StWait;
      StWait:    if (doneEvent || timeoutHit) stateD = StResp;
      StResp:    if (host.iResReady) stateD = StIdle;
      default:   stateD = StIdle;
    endcase
  end

  // State, job latch, done-edge tracking, timeout counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      modeQ     <= MODE_ENC;
      keyQ      <= '0;
      aQ        <= '0;
      bQ        <= '0;
      timerQ    <= '0;
      prevDoneQ <= 1'b0;
      resAQ     <= '0;
      resBQ     <= '0;
      resErrQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        modeQ <= host.iMode;
        keyQ  <= host.iKey;
        aQ    <= host.iA;
        bQ    <= host.iB;
      end
      if (stateQ == StStart) begin
        timerQ    <= '0;
        prevDoneQ <= selDone;
      end
      if (stateQ == StWait) begin
        timerQ    <= timerQ + 1'b1;
        prevDoneQ <= selDone;
      end
      if (doneEvent) begin
        resAQ   <= (modeQ == MODE_DEC) ? iCoreA_dec : iCoreA_enc;
        resBQ   <= (modeQ == MODE_DEC) ? iCoreB_dec : iCoreB_enc;
        resErrQ <= 1'b0;
      end else if (timeoutHit) begin
        resAQ   <= '0;
        resBQ   <= '0;
        resErrQ <= 1'b1;
      end
    end
  end

  // Handshake, start pulses and core block routing decoded from state
  always_comb begin
    busy           = (stateQ == StLoadKey) || (stateQ == StStart) || (stateQ == StWait);
    host.oJobReady = (stateQ == StIdle);
    host.oResValid = (stateQ == StResp);
    host.oResA     = resAQ;
    host.oResB     = resBQ;
    host.oResErr   = resErrQ;
    oStartCipher   = (stateQ == StStart) && (modeQ == MODE_ENC);
    oStartDecipher = (stateQ == StStart) && (modeQ == MODE_DEC);
    oCoreA         = (busy && modeQ == MODE_ENC) ? aQ : '0;
    oCoreB         = (busy && modeQ == MODE_ENC) ? bQ : '0;
    oCoreA_cipher  = (busy && modeQ == MODE_DEC) ? aQ : '0;
    oCoreB_cipher  = (busy && modeQ == MODE_DEC) ? bQ : '0;
  end

endmodule

// File: tb/tb_rc5_job_ctrl.sv
// tb_rc5_job_ctrl: randomized self-checking bench for rc5_job_ctrl with a behavioural core stub.
module tb_rc5_job_ctrl;

  localparam int unsigned W       = 64;
  localparam int unsigned B       = 16;
  localparam int unsigned BL      = 4;
  localparam int unsigned TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    oKey_sub_i;
  logic [BL-1:0] oKey_address;
  logic          oWen, oStartCipher, oStartDecipher;
  logic [W-1:0]  oCoreA, oCoreB, oCoreA_cipher, oCoreB_cipher;
  logic          iDoneCipher = 1'b0, iDoneDecipher = 1'b0;
  logic [W-1:0]  iCoreA_enc = '0, iCoreB_enc = '0, iCoreA_dec = '0, iCoreB_dec = '0;

  always #5 clk = ~clk;

  rc5_job_ctrl_if #(.W(W), .B(B)) hostIf ();

  rc5_job_ctrl #(.W(W), .B(B), .B_LENGTH(BL), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .host           (hostIf),
    .oKey_sub_i     (oKey_sub_i),
    .oKey_address   (oKey_address),
    .oWen           (oWen),
    .oStartCipher   (oStartCipher),
    .oStartDecipher (oStartDecipher),
    .oCoreA         (oCoreA),
    .oCoreB         (oCoreB),
    .oCoreA_cipher  (oCoreA_cipher),
    .oCoreB_cipher  (oCoreB_cipher),
    .iDoneCipher    (iDoneCipher),
    .iDoneDecipher  (iDoneDecipher),
    .iCoreA_enc     (iCoreA_enc),
    .iCoreB_enc     (iCoreB_enc),
    .iCoreA_dec     (iCoreA_dec),
    .iCoreB_dec     (iCoreB_dec)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: key cache contents (only relevant when the cache feature is built in)
  logic         mKeyValid = 1'b0;
  logic [127:0] mKey = '0;

  // Expectations from the model and observations of the last job
  int           expWen, expStart, expResp;
  logic [W-1:0] expA, expB;
  logic         expErr;
  int           wenCnt, wenBad, nC, nD, startIdx, respIdx, coreBad, readyBad, stableBad;
  int           gotResp;
  logic [W-1:0] obsA, obsB;
  logic         obsErr, readyAtHs, postValid, postReady;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Level of the selected done line, rel cycles after the start-pulse cycle
  function automatic logic lvl(input logic l0, input int lowAt, input int highAt, input int rel);
    if (highAt >= 0 && rel >= highAt) return 1'b1;
    if (lowAt >= 0 && rel >= lowAt) return 1'b0;
    return l0;
  endfunction

  task automatic drive_done(input logic m, input logic l);
    // The unused done line is driven opposite, so listening to the wrong one is visible
    iDoneCipher   = m ? ~l : l;
    iDoneDecipher = m ? l : ~l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hostIf.iJobValid = 1'b0;
    hostIf.iResReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mKeyValid = 1'b0;
  endtask

  // Offers one job from IDLE, plays the core stub, observes everything until the result
  // handshake completes. Fills exp* from the model and the observation variables.
  task automatic do_job(input logic m, input logic [127:0] k, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] encA, input logic [63:0] encB,
                        input logic [63:0] decA, input logic [63:0] decB, input logic l0,
                        input int lowAt, input int highAt, input int bp, input logic busyValid);
    int   ev, idx, rel;
    logic hit;
    hit = 1'b0;
`ifdef RC5_KEY_CACHE_EN
    hit = mKeyValid && (k == mKey);
`endif
    ev = -1;
    for (int r = 1; r <= int'(TIMEOUT) && ev < 0; r++)
      if (lvl(l0, lowAt, highAt, r) && !lvl(l0, lowAt, highAt, r - 1)) ev = r;
    expWen   = hit ? 0 : B;
    expStart = hit ? 0 : B;
    if (ev > 0) begin
      expErr  = 1'b0;
      expA    = m ? decA : encA;
      expB    = m ? decB : encB;
      expResp = expStart + 1 + ev;
    end else begin
      expErr  = 1'b1;
      expA    = '0;
      expB    = '0;
      expResp = expStart + TIMEOUT + 1;
    end
    if (!hit) begin
      mKeyValid = 1'b1;
      mKey      = k;
    end
    if (ev < 0) mKeyValid = 1'b0;

    iCoreA_enc = encA; iCoreB_enc = encB; iCoreA_dec = decA; iCoreB_dec = decB;
    hostIf.iJobValid = 1'b1;
    hostIf.iMode = m; hostIf.iKey = k; hostIf.iA = a; hostIf.iB = b;
    hostIf.iResReady = 1'b0;
    drive_done(m, l0);
    wenCnt = 0; wenBad = 0; nC = 0; nD = 0; startIdx = -1; respIdx = -1;
    coreBad = 0; readyBad = 0; stableBad = 0; gotResp = 0;
    @(posedge clk);
    #1;
    idx = 0;
    while (gotResp == 0 && idx < 400) begin
      hostIf.iJobValid = busyValid;
      hostIf.iMode = 1'($urandom); hostIf.iKey = rand128(); hostIf.iA = rand64();
      hostIf.iB = rand64();
      if (hostIf.oResValid) begin
        gotResp = 1; respIdx = idx;
        obsA = hostIf.oResA; obsB = hostIf.oResB; obsErr = hostIf.oResErr;
      end else begin
        if (oWen) begin
          if (wenCnt >= int'(B) || oKey_address !== BL'(wenCnt) ||
              oKey_sub_i !== k[8*wenCnt +: 8]) wenBad++;
          wenCnt++;
        end
        if (oStartCipher) nC++;
        if (oStartDecipher) nD++;
        if ((oStartCipher || oStartDecipher) && startIdx < 0) startIdx = idx;
        if (hostIf.oJobReady) readyBad++;
        if (oCoreA !== (m ? 64'd0 : a) || oCoreB !== (m ? 64'd0 : b) ||
            oCoreA_cipher !== (m ? a : 64'd0) || oCoreB_cipher !== (m ? b : 64'd0)) coreBad++;
        rel = (startIdx < 0) ? -1 : idx - startIdx;
        drive_done(m, lvl(l0, lowAt, highAt, rel));
        @(posedge clk);
        #1;
        idx++;
      end
    end
    if (gotResp != 0) begin
      for (int c = 0; c < bp; c++) begin
        @(posedge clk);
        #1;
        if (!hostIf.oResValid || hostIf.oResA !== obsA || hostIf.oResB !== obsB ||
            hostIf.oResErr !== obsErr || hostIf.oJobReady) stableBad++;
      end
      hostIf.iResReady = 1'b1;
      readyAtHs = hostIf.oJobReady;
      @(posedge clk);
      #1;
      postValid = hostIf.oResValid;
      postReady = hostIf.oJobReady;
      hostIf.iResReady = 1'b0;
      hostIf.iJobValid = 1'b0;
    end else begin
      do_reset();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (hostIf.oJobReady !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b want 1", hostIf.oJobReady); end
    checks++; if (hostIf.oResValid !== 1'b0 || hostIf.oResErr !== 1'b0) begin errors++;
      $display("FAIL reset_res: valid %b err %b want 0 0", hostIf.oResValid, hostIf.oResErr); end
    checks++; if ({oWen, oStartCipher, oStartDecipher} !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl: wen/sc/sd %b want 000", {oWen, oStartCipher, oStartDecipher}); end
    checks++; if ((oCoreA | oCoreB | oCoreA_cipher | oCoreB_cipher | hostIf.oResA | hostIf.oResB)
                  !== 64'd0) begin errors++;
      $display("FAIL reset_data: data outputs not zero"); end
  endtask

  task automatic test_encrypt();
    logic [63:0] ra, rb;
    ra = rand64(); rb = rand64();
    do_job(1'b0, 128'h0F0E0D0C0B0A09080706050403020100, 64'd0, 64'd0, ra, rb, rand64(),
           rand64(), 1'b0, -1, 10, 0, 1'b0);
    checks++; if (wenCnt !== expWen || wenBad !== 0) begin errors++;
      $display("FAIL enc_wen: count %0d bad %0d want %0d 0", wenCnt, wenBad, expWen); end
    checks++; if (nC !== 1 || nD !== 0 || startIdx !== expStart) begin errors++;
      $display("FAIL enc_start: nC %0d nD %0d at %0d want 1 0 %0d", nC, nD, startIdx, expStart); end
    checks++; if (gotResp !== 1 || respIdx !== expResp) begin errors++;
      $display("FAIL enc_latency: got %0d want %0d", respIdx, expResp); end
    checks++; if (obsA !== ra || obsB !== rb || obsErr !== 1'b0) begin errors++;
      $display("FAIL enc_result: got %h %h %b want %h %h 0", obsA, obsB, obsErr, ra, rb); end
    checks++; if (coreBad !== 0 || readyBad !== 0) begin errors++;
      $display("FAIL enc_busy: coreBad %0d readyBad %0d want 0 0", coreBad, readyBad); end
  endtask

  task automatic test_decrypt();
    logic [63:0] a, b, rb;
    a = rand64(); b = rand64(); rb = rand64();
    do_job(1'b1, 128'h0F0E0D0C0B0A09080706050403020100, a, b, rand64(), rand64(),
           64'h0123456789ABCDEF, rb, 1'b0, -1, 4, 0, 1'b0);
    checks++; if (nC !== 0 || nD !== 1 || startIdx !== expStart) begin errors++;
      $display("FAIL dec_start: nC %0d nD %0d at %0d want 0 1 %0d", nC, nD, startIdx, expStart); end
    checks++; if (obsA !== 64'h0123456789ABCDEF || obsB !== rb || obsErr !== 1'b0) begin errors++;
      $display("FAIL dec_result: got %h %h %b want 0123456789abcdef %h 0", obsA, obsB, obsErr, rb); end
    checks++; if (coreBad !== 0 || wenCnt !== expWen || wenBad !== 0) begin errors++;
      $display("FAIL dec_busy: coreBad %0d wen %0d bad %0d want 0 %0d 0", coreBad, wenCnt,
               wenBad, expWen); end
  endtask

  task automatic test_backpressure();
    do_job(1'($urandom), rand128(), rand64(), rand64(), rand64(), rand64(), rand64(), rand64(),
           1'b0, -1, 3, 5, 1'b1);
    checks++; if (gotResp !== 1 || stableBad !== 0) begin errors++;
      $display("FAIL bp_stable: resp %0d unstable %0d want 1 0", gotResp, stableBad); end
    checks++; if (obsA !== expA || obsB !== expB || obsErr !== expErr) begin errors++;
      $display("FAIL bp_result: got %h %h %b want %h %h %b", obsA, obsB, obsErr, expA, expB,
               expErr); end
    checks++; if (readyAtHs !== 1'b0 || postValid !== 1'b0 || postReady !== 1'b1) begin errors++;
      $display("FAIL bp_handshake: ready@hs %b valid/ready after %b%b want 0 01", readyAtHs,
               postValid, postReady); end
    checks++; if (readyBad !== 0 || wenBad !== 0 || coreBad !== 0) begin errors++;
      $display("FAIL bp_busy_inputs: ready %0d wen %0d core %0d want 0 0 0", readyBad, wenBad,
               coreBad); end
  endtask

  task automatic test_timeout();
    do_job(1'b0, rand128(), rand64(), rand64(), rand64(), rand64(), rand64(), rand64(),
           1'b0, -1, -1, 2, 1'b0);
    checks++; if (respIdx !== expResp || startIdx !== expStart) begin errors++;
      $display("FAIL timeout_len: resp %0d start %0d want %0d %0d", respIdx, startIdx, expResp,
               expStart); end
    checks++; if (obsErr !== 1'b1 || obsA !== 64'd0 || obsB !== 64'd0) begin errors++;
      $display("FAIL timeout_result: got %h %h %b want 0 0 1", obsA, obsB, obsErr); end
  endtask

  task automatic test_stale_done();
    logic [127:0] k;
    k = rand128();
    // First job leaves iDoneCipher high
    do_job(1'b0, k, rand64(), rand64(), rand64(), rand64(), rand64(), rand64(),
           1'b0, -1, 3, 0, 1'b0);
    do_job(1'b0, rand128(), rand64(), rand64(), rand64(), rand64(), rand64(), rand64(),
           1'b1, 4, 7, 0, 1'b0);
    checks++; if (respIdx !== expResp || obsErr !== 1'b0 || obsA !== expA) begin errors++;
      $display("FAIL stale_retrigger: resp %0d err %b want %0d 0", respIdx, obsErr, expResp); end
    // Done stays high forever: only a timeout may end the job
    do_job(1'b0, rand128(), rand64(), rand64(), rand64(), rand64(), rand64(), rand64(),
           1'b1, -1, -1, 0, 1'b0);
    checks++; if (respIdx !== expResp || obsErr !== 1'b1) begin errors++;
      $display("FAIL stale_level: resp %0d err %b want %0d 1", respIdx, obsErr, expResp); end
  endtask

  task automatic test_reset_midjob();
    int n, starts, wens;
    hostIf.iJobValid = 1'b1; hostIf.iMode = 1'b0; hostIf.iKey = rand128();
    hostIf.iA = rand64(); hostIf.iB = rand64();
    drive_done(1'b0, 1'b0);
    @(posedge clk);
    #1;
    hostIf.iJobValid = 1'b0;
    n = 0;
    while (!(oWen && oKey_address == BL'(7)) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++; if (n >= 50) begin errors++;
      $display("FAIL midrst_reach: address 7 not seen within %0d cycles", n); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mKeyValid = 1'b0;
    checks++; if (oWen !== 1'b0 || hostIf.oJobReady !== 1'b1) begin errors++;
      $display("FAIL midrst_abort: wen %b ready %b want 0 1", oWen, hostIf.oJobReady); end
    starts = 0; wens = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (oStartCipher || oStartDecipher) starts++;
      if (oWen) wens++;
    end
    checks++; if (starts !== 0 || wens !== 0) begin errors++;
      $display("FAIL midrst_quiet: starts %0d wens %0d want 0 0", starts, wens); end
  endtask

  task automatic test_random();
    logic [127:0] k, lastK;
    int           lowAt, highAt;
    lastK = rand128();
    for (int j = 0; j < 10; j++) begin
      k      = ($urandom_range(0, 2) == 0) ? lastK : rand128();
      lastK  = k;
      lowAt  = $urandom_range(1, 4);
      highAt = ($urandom_range(0, 5) == 0) ? -1 : lowAt + $urandom_range(1, 30);
      do_job(1'($urandom), k, rand64(), rand64(), rand64(), rand64(), rand64(), rand64(),
             1'($urandom), lowAt, highAt, $urandom_range(0, 3), 1'($urandom));
      checks++; if (wenCnt !== expWen || wenBad !== 0 || startIdx !== expStart ||
                    nC + nD !== 1) begin errors++;
        $display("FAIL rand%0d_load: wen %0d bad %0d start %0d pulses %0d want %0d 0 %0d 1", j,
                 wenCnt, wenBad, startIdx, nC + nD, expWen, expStart); end
      checks++; if (respIdx !== expResp || obsA !== expA || obsB !== expB ||
                    obsErr !== expErr) begin errors++;
        $display("FAIL rand%0d_result: at %0d %h %h %b want at %0d %h %h %b", j, respIdx, obsA,
                 obsB, obsErr, expResp, expA, expB, expErr); end
      checks++; if (coreBad !== 0 || readyBad !== 0 || stableBad !== 0 ||
                    postReady !== 1'b1) begin errors++;
        $display("FAIL rand%0d_proto: core %0d ready %0d stable %0d postReady %b", j, coreBad,
                 readyBad, stableBad, postReady); end
    end
  endtask

  initial begin
    hostIf.iJobValid = 1'b0; hostIf.iMode = 1'b0; hostIf.iKey = '0;
    hostIf.iA = '0; hostIf.iB = '0; hostIf.iResReady = 1'b0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_timeout();
    test_stale_done();
    test_reset_midjob();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rc5_job_ctrl.md
Name: rc5_job_ctrl

Overview:
- Job sequencer in front of the RC5 cipher/decipher core.
- Accepts one job per valid/ready handshake: a 128-bit key, one 2-word block, and a mode (encrypt or decrypt).
- Per job: writes the key bytes into the core's key memory, pulses the matching start, waits for done, then returns the result words via valid/ready with a timeout/error flag.
- Sits between the host-side job source and the core's key/start/data ports.

Parameters:
- W, 64, word width in bits (block = 2 words)
- B, 16, key length in bytes
- B_LENGTH, $clog2(B), key address width
- TIMEOUT, 4096, max cycles from start pulse to done before abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- iJobValid  in  1  job offered
- oJobReady  out  1  controller can accept job
- iMode  in  1  0=encrypt, 1=decrypt
- iKey  in  8*B  key; byte k = iKey[8k+7:8k]
- iA  in  W  block word A (plaintext or ciphertext)
- iB  in  W  block word B
- oResValid  out  1  result available
- iResReady  in  1  consumer accepts result
- oResA  out  W  result word A
- oResB  out  W  result word B
- oResErr  out  1  1 = job timed out; result words are 0
- oKey_sub_i  out  8  key byte to core
- oKey_address  out  B_LENGTH  key memory address
- oWen  out  1  key memory write enable
- oStartCipher  out  1  one-cycle start pulse, encrypt
- oStartDecipher  out  1  one-cycle start pulse, decrypt
- oCoreA, oCoreB  out  W  plaintext to core cipher inputs
- oCoreA_cipher, oCoreB_cipher  out  W  ciphertext to core decipher inputs
- iDoneCipher, iDoneDecipher  in  1  core done flags
- iCoreA_enc, iCoreB_enc, iCoreA_dec, iCoreB_dec  in  W  core result words

Behaviour:
- Reset: state IDLE. All outputs 0 except oJobReady=1. Job registers cleared. Reset mid-job aborts immediately; no start or write pulse follows.
- Registered FSM: IDLE, LOAD_KEY, START, WAIT, RESP.
- IDLE:
  - oJobReady=1.
  - On iJobValid & oJobReady, latch iMode, iKey, iA, iB; go to LOAD_KEY.
  - oJobReady drops the cycle after acceptance and stays 0 until RESP completes.
- LOAD_KEY:
  - B cycles; oWen=1, oKey_address=k, oKey_sub_i=key byte k, k=0..B-1.
  - After address B-1, go to START.
- START:
  - One cycle. oStartCipher=1 if mode=0, else oStartDecipher=1; never both.
  - Clear timeout counter; sample selected done into prevDone; go to WAIT.
- WAIT:
  - Done event = selected done is 1 and prevDone is 0 (rising edge). A done level left high from a previous job is ignored.
  - On done event, capture the mode-selected core results into oResA/oResB, oResErr=0; go to RESP.
  - Counter increments each WAIT cycle. When it reaches TIMEOUT-1 without a done event: oResA=oResB=0, oResErr=1; go to RESP.
  - A done event in the same cycle as the timeout wins (no error).
- RESP:
  - oResValid=1. Outputs hold stable while iResReady=0.
  - On iResReady, go to IDLE; oResValid=0 the next cycle.
- Core data outputs (oCoreA/B, oCoreA_cipher/B_cipher):
  - Driven from the latched block every cycle from LOAD_KEY through WAIT.
  - Plain pair carries the block when mode=0; cipher pair carries it when mode=1; the unused pair is 0.
- Minimum latency, acceptance to oResValid: B + 2 + core latency cycles.
- Inputs presented during a busy state are not sampled.

Optional Feature:
- Macro: RC5_KEY_CACHE_EN.
- Defined:
  - Controller keeps the last fully loaded key and a keyValid bit (cleared by reset and by a timeout).
  - If an accepted job's key equals the cached key and keyValid=1, skip LOAD_KEY (IDLE→START); no oWen pulses.
- Undefined: every job loads the key; no cache storage is synthesized.

Decomposition:
- Package rc5_pkg: W, B, B_LENGTH, PW/QW constants, mode encoding (MODE_ENC=0, MODE_DEC=1), FSM state encoding.
- One sub-module: rc5_key_loader. Byte counter plus address/data/wen generation; start input, done output after B writes.

Test Plan:
- Encrypt job, key bytes 0x00..0x0F, A=0, B=0 → oWen high exactly 16 cycles with addresses 0..15 and data 0x00..0x0F. Then one oStartCipher pulse, no oStartDecipher. Stub asserts done 10 cycles later → oResValid with stub results, oResErr=0.
- Decrypt job with the same key, core stub returns A=0x0123456789ABCDEF → oStartDecipher only; oResA=0x0123456789ABCDEF taken from the decipher outputs.
- Result backpressure: iResReady=0 for 5 cycles → oResValid, oResA, oResB stable; oJobReady=0; a second iJobValid is not accepted until the cycle after the handshake.
- Timeout with TIMEOUT=64 and stub never raising done → exactly 64 WAIT cycles, then oResErr=1, oResA=oResB=0.
- Stale done: iDoneCipher held high from the previous job through the next start → no completion until done falls and rises again.
- rst asserted during LOAD_KEY at address 7 → next cycle oWen=0, oJobReady=1, no start pulse. With RC5_KEY_CACHE_EN: two back-to-back jobs with the same key → second job has zero oWen cycles; the start pulse arrives one cycle after acceptance.
